// File: rtl/squeeze_buffer_pkg.sv
// rtl/squeeze_buffer_pkg.sv - shared types and constants for the squeeze output stage
package squeeze_buffer_pkg;

  localparam int WORD_W              = 64;
  localparam int RATE_SHAKE128_WORDS = 21;
  localparam int RATE_SHAKE256_WORDS = 17;

  localparam logic [1:0] SHAKE128_MODE_VEC = 2'b10;
  localparam logic [1:0] SHAKE256_MODE_VEC = 2'b11;

  typedef enum logic {
    EMPTY   = 1'b0,
    SQUEEZE = 1'b1
  } squeeze_state_t;

  // Words per rate block; zero marks a mode that produces no output.
  function automatic logic [4:0] block_words(input logic [1:0] mode);
    case (mode)
      SHAKE128_MODE_VEC: block_words = 5'(RATE_SHAKE128_WORDS);
      SHAKE256_MODE_VEC: block_words = 5'(RATE_SHAKE256_WORDS);
      default:           block_words = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/squeeze_buffer_if.sv
// rtl/squeeze_buffer_if.sv - block capture and word stream signals of the squeeze stage
interface squeeze_buffer_if #(
  parameter int W        = 64,
  parameter int RATE_MAX = 1344
);
  logic [RATE_MAX-1:0] rate_in;
  logic [1:0]          operation_mode_in;
  logic [31:0]         output_size_in;
  logic                last_block_in;
  logic                block_valid;
  logic                block_ready;
  logic [W-1:0]        dout;
  logic                dout_valid;
  logic                dout_ready;
  logic                dout_last;

  modport slave (
    input  rate_in, operation_mode_in, output_size_in, last_block_in, block_valid, dout_ready,
    output block_ready, dout, dout_valid, dout_last
  );

  modport master (
    output rate_in, operation_mode_in, output_size_in, last_block_in, block_valid, dout_ready,
    input  block_ready, dout, dout_valid, dout_last
  );
endinterface

// File: rtl/squeeze_buffer_tail_mask.sv
// rtl/squeeze_buffer_tail_mask.sv - keep mask for the top bits_left bits of an output word
module word_tail_mask #(
  parameter int W = 64
) (
  input  logic [31:0]  bits_left,
  output logic [W-1:0] keep_mask
);
  localparam int SHW = $clog2(W);

  always_comb begin
    keep_mask = '1;
    if (bits_left < 32'(W)) begin
      keep_mask = ~({W{1'b1}} >> bits_left[SHW-1:0]);
    end
  end
endmodule

// File: rtl/squeeze_buffer.sv
// rtl/squeeze_buffer.sv - holds one permuted rate block and streams it out as truncated words
module squeeze_buffer
  import squeeze_buffer_pkg::*;
#(
  parameter int W        = 64,
  parameter int RATE_MAX = 1344
) (
  input logic            clk,
  input logic            rst,
  squeeze_buffer_if.slave bus
);

  squeeze_state_t      state_q, state_d;
  logic [RATE_MAX-1:0] shift_q, shift_d;
  logic [4:0]          words_q, words_d;
  logic [31:0]         bits_left_q, bits_left_d;
  logic                last_q, last_d;

  logic [4:0]   blk_words;
  logic [31:0]  size_words;
  logic [4:0]   take_words;
  logic         capture_ok;
  logic         final_word;
  logic [W-1:0] keep_mask;

  logic         block_ready;
  logic         dout_valid;
  logic         dout_last;
  logic [W-1:0] dout;

  word_tail_mask #(.W(W)) u_tail_mask (
    .bits_left (bits_left_q),
    .keep_mask (keep_mask)
  );

  // ceil(size/64) without overflow, clipped to the block length
  always_comb begin
    blk_words  = block_words(bus.operation_mode_in);
    size_words = {6'd0, bus.output_size_in[31:6]} + {31'd0, |bus.output_size_in[5:0]};
    take_words = (size_words < {27'd0, blk_words}) ? size_words[4:0] : blk_words;
    capture_ok = (blk_words != 5'd0) && (bus.output_size_in != 32'd0);
    final_word = (words_q == 5'd1);
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    words_d     = words_q;
    bits_left_d = bits_left_q;
    last_d      = last_q;
    block_ready = 1'b0;
    dout_valid  = 1'b0;
    dout_last   = 1'b0;
    dout        = '0;
    case (state_q)
      EMPTY: begin
        block_ready = 1'b1;
        if (bus.block_valid && capture_ok) begin
          shift_d     = bus.rate_in;
          words_d     = take_words;
          bits_left_d = bus.output_size_in;
          last_d      = bus.last_block_in;
          state_d     = SQUEEZE;
        end
      end
      SQUEEZE: begin
        dout_valid = 1'b1;
        dout       = shift_q[RATE_MAX-1 -: W] & keep_mask;
        dout_last  = last_q && final_word;
        if (bus.dout_ready) begin
          shift_d     = shift_q << W;
          words_d     = words_q - 5'd1;
          bits_left_d = (bits_left_q >= 32'(W)) ? bits_left_q - 32'(W) : 32'd0;
          if (final_word) begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      shift_q     <= '0;
      words_q     <= '0;
      bits_left_q <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      words_q     <= words_d;
      bits_left_q <= bits_left_d;
      last_q      <= last_d;
    end
  end

  assign bus.block_ready = block_ready;
  assign bus.dout_valid  = dout_valid;
  assign bus.dout_last   = dout_last;
  assign bus.dout        = dout;

endmodule

// File: tb/tb_squeeze_buffer.sv
// tb/tb_squeeze_buffer.sv - randomized self-checking bench for squeeze_buffer
module tb_squeeze_buffer;
  import squeeze_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  squeeze_buffer_if #(.W(64), .RATE_MAX(1344)) bus ();
  squeeze_buffer #(.W(64), .RATE_MAX(1344)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [1343:0] rand_rate();
    logic [1343:0] r;
    for (int i = 0; i < 42; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int exp_words(input logic [1:0] mode, input logic [31:0] size);
    longint n;
    int blk;
    blk = (mode == SHAKE128_MODE_VEC) ? 21 : (mode == SHAKE256_MODE_VEC) ? 17 : 0;
    n = (longint'(size) + 63) / 64;
    if (size == 0) return 0;
    return (n < longint'(blk)) ? int'(n) : blk;
  endfunction

  // word i of the stream: the i-th 64-bit slice from the MSB, bits past the output size zeroed
  function automatic logic [63:0] exp_word(input logic [1343:0] rate, input int i, input logic [31:0] size);
    logic [63:0] w;
    longint rem;
    w   = rate[1343 - 64*i -: 64];
    rem = longint'(size) - 64 * longint'(i);
    for (int b = 0; b < 64; b++) if (longint'(b) >= rem) w[63-b] = 1'b0;
    return w;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_block_ready"}, 64'(bus.block_ready), 64'd1);
    chk({tag, "_dout_valid"},  64'(bus.dout_valid),  64'd0);
    chk({tag, "_dout"},        bus.dout,             64'd0);
    chk({tag, "_dout_last"},   64'(bus.dout_last),   64'd0);
  endtask

  task automatic run_block(input logic [1343:0] rate, input logic [1:0] mode, input logic [31:0] size,
                           input logic last, input int stall_pct, input int abort_at);
    int n;
    int idx;
    int cyc;
    logic [63:0] prev;
    logic stalled;
    n = exp_words(mode, size);
    idx = 0;
    stalled = 1'b0;
    prev = '0;
    @(negedge clk);
    chk("ready_before", 64'(bus.block_ready), 64'd1);
    bus.rate_in           = rate;
    bus.operation_mode_in = mode;
    bus.output_size_in    = size;
    bus.last_block_in     = last;
    bus.block_valid       = 1'b1;
    bus.dout_ready        = 1'b1;
    @(negedge clk);
    bus.block_valid = 1'b0;
    cyc = 1;
    if (n == 0) begin
      repeat (3) begin
        chk("discard_valid", 64'(bus.dout_valid), 64'd0);
        chk("discard_ready", 64'(bus.block_ready), 64'd1);
        @(negedge clk);
      end
      return;
    end
    while (idx < n && cyc < 2000) begin
      if (abort_at >= 0 && idx == abort_at) begin
        rst = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      chk("busy_ready", 64'(bus.block_ready), 64'd0);
      chk("busy_valid", 64'(bus.dout_valid), 64'd1);
      if (stalled) chk("stall_hold", bus.dout, prev);
      bus.dout_ready = ($urandom_range(99) >= 32'(stall_pct));
      if (bus.dout_ready) begin
        chk($sformatf("word%0d", idx), bus.dout, exp_word(rate, idx, size));
        chk($sformatf("last%0d", idx), 64'(bus.dout_last), 64'(last && (idx == n - 1)));
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        prev = bus.dout;
      end
      @(negedge clk);
      cyc++;
    end
    chk("word_count", 64'(idx), 64'(n));
    chk("ready_after", 64'(bus.block_ready), 64'd1);
    chk("idle_valid", 64'(bus.dout_valid), 64'd0);
    if (stall_pct == 0) chk("ready_latency", 64'(cyc), 64'(n + 1));
  endtask

  initial begin
    logic [1343:0] r;
    logic [1:0] m;
    rst = 1'b0;
    bus.rate_in = '0;
    bus.operation_mode_in = 2'b00;
    bus.output_size_in = '0;
    bus.last_block_in = 1'b0;
    bus.block_valid = 1'b0;
    bus.dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    run_block(rand_rate(), SHAKE128_MODE_VEC, 32'd256,  1'b1, 0, -1);
    run_block(rand_rate(), SHAKE256_MODE_VEC, 32'd4000, 1'b0, 0, -1);
    run_block(rand_rate(), SHAKE128_MODE_VEC, 32'd100,  1'b1, 0, -1);
    run_block(rand_rate(), SHAKE128_MODE_VEC, 32'd2000, 1'b1, 40, -1);
    run_block(rand_rate(), SHAKE128_MODE_VEC, 32'd1344, 1'b1, 0, -1);
    run_block(rand_rate(), SHAKE128_MODE_VEC, 32'd1300, 1'b1, 25, -1);
    run_block(rand_rate(), SHAKE256_MODE_VEC, 32'd1,    1'b1, 0, -1);
    run_block(rand_rate(), 2'b00,             32'd256,  1'b1, 0, -1);
    run_block(rand_rate(), 2'b01,             32'd256,  1'b1, 0, -1);
    run_block(rand_rate(), SHAKE128_MODE_VEC, 32'd0,    1'b1, 0, -1);
    run_block(rand_rate(), SHAKE128_MODE_VEC, 32'hFFFF_FFFF, 1'b1, 0, 10);
    run_block(rand_rate(), SHAKE128_MODE_VEC, 32'hFFFF_FFFF, 1'b1, 0, -1);

    for (int t = 0; t < 8; t++) begin
      r = rand_rate();
      m = 2'($urandom_range(3));
      if ($urandom_range(3) != 0) m = (m[0]) ? SHAKE256_MODE_VEC : SHAKE128_MODE_VEC;
      run_block(r, m, $urandom_range(1500), 1'($urandom_range(1)), 30, -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
